// File: rtl/prbs10_checker_pkg.sv
// Shared types and constants for the PRBS10 (x^10 + x^7 + 1) checker and its
// LFSR step logic.
package prbs10_checker_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int PRBS_W    = 10;
  localparam int TAP_A     = 9;
  localparam int TAP_B     = 6;

  localparam int ERR_CNT_W = 16;
  localparam int BIT_CNT_W = 24;

  // The fill phase loads exactly PRBS_W bits before any comparison.
  localparam int                FILL_W   = 4;
  localparam logic [FILL_W-1:0] FILL_LEN = FILL_W'(PRBS_W);

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [BIT_CNT_W-1:0] sat_inc_bit(input logic [BIT_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/prbs10_step.sv
// Combinational PRBS10 step: prediction from the taps and the shifted next state.
// Shared by checker and generator so both sides agree on bit ordering.
module prbs10_step
  import prbs10_checker_pkg::*;
(
  input  logic [PRBS_W-1:0] state_i,
  input  logic              in_bit_i,
  output logic              pred_o,
  output logic [PRBS_W-1:0] next_o
);

  assign pred_o = state_i[TAP_A] ^ state_i[TAP_B];
  assign next_o = {state_i[PRBS_W-2:0], in_bit_i};

endmodule

// File: rtl/prbs10_checker.sv
// PRBS10 checker: self-synchronising search, free-running reference once locked,
// windowed loss-of-lock detection and saturating error/bit statistics.
module prbs10_checker
  import prbs10_checker_pkg::*;
#(
  parameter int LOCK_MATCHES = 16,
  parameter int WIN_LEN      = 64,
  parameter int WIN_ERR_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 din,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count
);

  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int WB_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WE_W    = $clog2(WIN_ERR_MAX + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [WB_W-1:0]    WIN_LAST   = WB_W'(WIN_LEN - 1);
  localparam logic [WE_W-1:0]    ERR_LAST   = WE_W'(WIN_ERR_MAX - 1);

  state_e                 state_q, state_d;
  logic [PRBS_W-1:0]      s_q, s_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic [WB_W-1:0]        win_bits_q, win_bits_d;
  logic [WE_W-1:0]        win_errs_q, win_errs_d;
  logic                   locked_q, locked_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic                   pred;
  logic                   shift_in;
  logic [PRBS_W-1:0]      s_next;
  logic                   mismatch;

  // Once locked the reference runs on its own prediction, so line errors
  // cannot corrupt it.
  assign shift_in = (state_q == LOCKED) ? pred : din;
  assign mismatch = din ^ pred;

  prbs10_step u_step (
    .state_i  (s_q),
    .in_bit_i (shift_in),
    .pred_o   (pred),
    .next_o   (s_next)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;

    if (bit_en) begin
      s_d = s_next;
      unique case (state_q)
        SEARCH: begin
          if (fill_q != FILL_LEN) begin
            fill_d = fill_q + 1'b1;
          end else if (!mismatch && (s_q != '0)) begin
            if (match_q == MATCH_LAST) begin
              state_d    = LOCKED;
              match_d    = '0;
              win_bits_d = '0;
              win_errs_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          bit_cnt_d = sat_inc_bit(bit_cnt_q);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc_err(err_cnt_q);
          end
          // The error that fills the window still counts before lock is dropped.
          if (mismatch && (win_errs_q == ERR_LAST)) begin
            state_d    = SEARCH;
            fill_d     = '0;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_q == WIN_LAST) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + 1'b1;
            win_errs_d = win_errs_q + WE_W'(mismatch);
          end
        end

        default: state_d = SEARCH;
      endcase
    end

    if (clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs10_checker.sv
// Bench for prbs10_checker: a recurrence-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_prbs10_checker;

  localparam int LOCK_MATCHES = 16;
  localparam int WIN_LEN      = 64;
  localparam int WIN_ERR_MAX  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0;
  logic        din = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [23:0] bit_count;

  int checks   = 0;
  int failures = 0;

  prbs10_checker #(
    .LOCK_MATCHES (LOCK_MATCHES),
    .WIN_LEN      (WIN_LEN),
    .WIN_ERR_MAX  (WIN_ERR_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .din       (din),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bit n of the reference sequence is b[n-10] ^ b[n-7].
  bit          m_locked = 1'b0;
  bit          m_pulse  = 1'b0;
  int          m_fill = 0, m_match = 0, m_wbits = 0, m_werrs = 0;
  int unsigned m_err = 0, m_bits = 0;
  bit          ref_q[$];
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    bit p, all_zero, bad;
    if (rst) begin
      m_locked = 0; m_pulse = 0;
      m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
      m_err = 0; m_bits = 0;
      ref_q.delete();
      repeat (10) ref_q.push_back(1'b0);
    end else begin
      m_pulse = 0;
      if (bit_en) begin
        p = ref_q[0] ^ ref_q[3];
        all_zero = 1'b1;
        foreach (ref_q[i]) if (ref_q[i]) all_zero = 1'b0;
        if (!m_locked) begin
          if (m_fill < 10) m_fill++;
          else if (din == p && !all_zero) begin
            m_match++;
            if (m_match == LOCK_MATCHES) begin
              m_locked = 1; m_match = 0; m_wbits = 0; m_werrs = 0;
            end
          end else m_match = 0;
          ref_q.push_back(din);
        end else begin
          bad = (din != p);
          if (m_bits < 32'hFF_FFFF) m_bits++;
          if (bad) begin
            m_pulse = 1;
            if (m_err < 32'hFFFF) m_err++;
            m_werrs++;
          end
          m_wbits++;
          if (m_werrs == WIN_ERR_MAX) begin
            m_locked = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
          end else if (m_wbits == WIN_LEN) begin
            m_wbits = 0; m_werrs = 0;
          end
          ref_q.push_back(p);
        end
        void'(ref_q.pop_front());
      end
      if (clr) begin m_err = 0; m_bits = 0; end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_locked",    32'(locked),    32'(m_locked));
      check("cyc_err_pulse", 32'(err_pulse), 32'(m_pulse));
      check("cyc_err_count", 32'(err_count), m_err);
      check("cyc_bit_count", 32'(bit_count), m_bits);
    end
  end

  // Upstream generator, seeded 10'h3FF.
  logic [9:0] g = 10'h3FF;

  task automatic gen(output bit b);
    b = g[9] ^ g[6];
    g = {g[8:0], b};
  endtask

  task automatic step(input bit en, input bit d, input bit c);
    bit_en = en; din = d; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic send_clean();
    bit b;
    gen(b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic send_bad(input bit c);
    bit b;
    gen(b);
    step(1'b1, ~b, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Counts bits until locked is seen, bounded at 200 bits.
  task automatic wait_lock(input int period, output int nbits);
    nbits = 0;
    while (!locked && nbits < 200) begin
      repeat (period - 1) step(1'b0, 1'b0, 1'b0);
      send_clean();
      nbits++;
    end
  endtask

  initial begin
    int n;
    int bad_cnt;

    do_reset();
    cmp_en = 1'b1;
    check("rst_locked",    32'(locked),    0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_bit_count", 32'(bit_count), 0);

    // Clean stream, bit_en every cycle.
    wait_lock(1, n);
    check("lock_after_26_bits", 32'(n), 26);
    repeat (1000) send_clean();
    check("clean_err_count", 32'(err_count), 0);
    check("clean_bit_count", 32'(bit_count), 1000);

    // One inverted bit every 100 bits, five times.
    for (int k = 0; k < 5; k++) begin
      send_bad(1'b0);
      check("single_err_pulse_hi", 32'(err_pulse), 1);
      send_clean();
      check("single_err_pulse_lo", 32'(err_pulse), 0);
      repeat (98) send_clean();
    end
    check("single_err_count", 32'(err_count), 5);
    check("single_still_locked", 32'(locked), 1);

    // Eight consecutive errors at the start of a window drop lock.
    step(1'b0, 1'b0, 1'b1);
    check("clr_idle_err_count", 32'(err_count), 0);
    while (m_wbits != 0) send_clean();
    repeat (7) send_bad(1'b0);
    check("burst7_locked", 32'(locked), 1);
    send_bad(1'b0);
    check("burst8_unlocked", 32'(locked), 0);
    check("burst8_err_pulse", 32'(err_pulse), 1);
    check("burst8_err_count", 32'(err_count), 8);
    wait_lock(1, n);
    check("relock_after_26_bits", 32'(n), 26);
    check("relock_err_count", 32'(err_count), 8);

    // All-zero stream never locks and never matches.
    do_reset();
    bad_cnt = 0;
    repeat (200) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0 || dut.match_q != 0) bad_cnt++;
    end
    check("zero_stream_no_match", 32'(bad_cnt), 0);

    // Sparse bit_en: one in three cycles.
    do_reset();
    g = 10'h3FF;
    wait_lock(3, n);
    check("sparse_lock_after_26_bits", 32'(n), 26);
    send_bad(1'b0);
    check("pre_clr_err_count", 32'(err_count), 1);
    send_bad(1'b1);
    check("clr_with_err_count", 32'(err_count), 0);
    check("clr_with_err_pulse", 32'(err_pulse), 1);
    check("clr_with_err_bits", 32'(bit_count), 0);

    // Reset while locked with three errors counted.
    for (int k = 0; k < 3; k++) begin
      send_bad(1'b0);
      repeat (4) send_clean();
    end
    check("pre_rst_err_count", 32'(err_count), 3);
    check("pre_rst_locked", 32'(locked), 1);
    rst = 1'b1;
    send_bad(1'b1);
    rst = 1'b0;
    check("midrst_locked",    32'(locked),    0);
    check("midrst_err_pulse", 32'(err_pulse), 0);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_bit_count", 32'(bit_count), 0);
    wait_lock(1, n);
    check("post_rst_lock_after_26_bits", 32'(n), 26);

    step(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
